hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

Forwarding and load-use hazard controller for the pipelined core. It sits directly upstream of the EX-stage 3:1 operand multiplexers and drives their 2-bit select inputs. It compares the source registers of the instruction in ID against the destinations of the instructions in EX, MEM and WB. It registers the forwarding selects so they are valid while the consumer is in EX, and inserts load-use bubbles through a small stall state machine.

## Interface
Parameters:
- REG_ADDR_W, 4, register index width (16 architectural registers; index 0 reads as zero and is never forwarded)
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  branch/redirect kill from EX; cancels any pending stall
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  ID source indices
- id_rs1_used, id_rs2_used  in  1  source is actually read by the ID instruction
- ex_valid, ex_we, ex_is_load  in  1  EX instruction valid / writes a register / is a load
- ex_rd  in  REG_ADDR_W  EX destination
- mem_valid, mem_we  in  1  MEM instruction valid / writes a register
- mem_rd  in  REG_ADDR_W  MEM destination
- fwd_a_sel, fwd_b_sel  out  2  EX operand mux selects: 00 register file, 01 WB result, 10 MEM result; 11 never driven
- stall  out  1  freeze PC and IF/ID register
- bubble  out  1  load NOP into ID/EX register

## Operation
- Producer match (per source s, index src): producer valid & we & rd == src & rd != 0 & id_s_used.
- Select computed in ID, registered for EX use: EX-stage producer match -> 10 (it will be in MEM), else MEM-stage producer match -> 01 (it will be in WB), else 00. EX match wins over MEM match (newest value).
- Load-use hazard: id_valid & ex_valid & ex_is_load & ex producer match on either used source.
- FSM states: RUN, STALL.
  - RUN: hazard -> go STALL, load counter with LOAD_LAT-1, assert stall and bubble combinationally that same cycle; fwd selects hold their previous values.
  - RUN, no hazard, id_valid: fwd selects register the computed values at the edge.
  - RUN, id_valid=0: selects register 00.
  - STALL: stall=bubble=1; counter decrements each cycle. At counter==0 -> RUN; hazard is re-evaluated in RUN against the then-current EX/MEM contents.
  - Hazard detection is suppressed while in STALL.
- With LOAD_LAT=1 a dependent instruction following a load gets exactly one bubble and then select 01. With LOAD_LAT>=2 the load has retired and select 00 applies; this requires write-before-read in the register file.
- flush: FSM -> RUN, counter -> 0, selects -> 00 at the edge. stall/bubble are deasserted the same cycle flush is high. flush has priority over hazard detection.

## Timing
- Reset values: fwd_a_sel=00, fwd_b_sel=00, stall=0, bubble=0, FSM=RUN, counter=0. Any reset mid-STALL returns to RUN on the next edge.
- stall/bubble: combinational from the current inputs and state, zero latency. Exactly LOAD_LAT consecutive cycles per hazard.
- fwd selects: one-cycle latency. Values registered at the edge where ID advances (stall=0) are constant throughout the consumer's EX cycle.
- Back-to-back loads feeding each other: each hazard independently costs LOAD_LAT cycles.
- Same register written by both EX and MEM producers: select 10.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds output port stall_cycles [31:0], counting cycles with stall=1.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by rst; flush does not clear it.
- HAZARD_PERF_CNT_EN undefined:
  - Port absent, no counter logic.
  - All other behaviour identical.

## Test plan
- Reset: hold rst=1 for 2 cycles with random inputs -> selects 00, stall=0, bubble=0 (and stall_cycles=0 if enabled).
- ALU chain: EX writes r3 (non-load), ID reads rs1=r3 -> next cycle fwd_a_sel=10, fwd_b_sel=00, no stall.
- Two-back dependency: MEM writes r5, EX writes r6, ID reads rs1=r5, rs2=r6 -> fwd_a_sel=01, fwd_b_sel=10. Also ID rs1=r0 with EX rd=r0 -> 00.
- Load-use, LOAD_LAT=1: load r7 in EX, ID reads r7 -> stall=bubble=1 for exactly 1 cycle, then fwd_a_sel=01. With LOAD_LAT=3 -> 3 stall cycles, then select 00, and stall_cycles increments by 3.
- Flush mid-stall, LOAD_LAT=3: assert flush in the 2nd stall cycle -> stall=0 that cycle, FSM RUN, selects 00 next cycle.
- Priority: EX and MEM both write r2 and ID reads r2 on both sources -> both selects 10.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX-stage operand forwarding selects and load-use stall control.
// The selects are computed in ID from the EX/MEM producers and registered, so they
// stay stable while the consumer sits in EX. A load feeding the next instruction
// stalls ID for LOAD_LAT cycles: the detection cycle plus LOAD_LAT-1 cycles in STALL.
// Optional build macro HAZARD_PERF_CNT_EN adds a saturating stall_cycles counter.
// Signal qualifiers: *_valid marks a real instruction in a stage. *_we and *_used
// only count when the matching *_valid is high. There is no ready/backpressure
// input; stall is the only backpressure this block produces.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_valid,
    input  logic                  ex_we,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  bubble,
    output logic                  state_dbg
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Remaining stall cycles after the detection cycle.
    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] sel_a_d, sel_b_d;
    logic [1:0] sel_a_calc, sel_b_calc;
    logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic       hazard;

    // Producer matches. Register 0 is hard-wired zero, so it is never forwarded.
    assign ex_hit_a  = ex_valid  & ex_we  & id_rs1_used & (ex_rd  == id_rs1) & (ex_rd  != '0);
    assign ex_hit_b  = ex_valid  & ex_we  & id_rs2_used & (ex_rd  == id_rs2) & (ex_rd  != '0);
    assign mem_hit_a = mem_valid & mem_we & id_rs1_used & (mem_rd == id_rs1) & (mem_rd != '0);
    assign mem_hit_b = mem_valid & mem_we & id_rs2_used & (mem_rd == id_rs2) & (mem_rd != '0);

    // The EX producer is the newest value, so it wins over MEM.
    assign sel_a_calc = ex_hit_a ? SEL_MEM : (mem_hit_a ? SEL_WB : SEL_RF);
    assign sel_b_calc = ex_hit_b ? SEL_MEM : (mem_hit_b ? SEL_WB : SEL_RF);

    // A load in EX cannot be forwarded yet, so the consumer has to wait.
    assign hazard = id_valid & ex_valid & ex_is_load & (ex_hit_a | ex_hit_b);

    assign state_dbg = state_q;

    // Next-state, stall counter, select update and stall/bubble outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_a_d = fwd_a_sel;
        sel_b_d = fwd_b_sel;
        stall   = 1'b0;
        bubble  = 1'b0;
        if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
            sel_a_d = SEL_RF;
            sel_b_d = SEL_RF;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        stall   = 1'b1;
                        bubble  = 1'b1;
                        cnt_d   = LAT_M1;
                        state_d = (LAT_M1 != 3'd0) ? STALL : RUN;
                    end else if (id_valid) begin
                        sel_a_d = sel_a_calc;
                        sel_b_d = sel_b_calc;
                    end else begin
                        sel_a_d = SEL_RF;
                        sel_b_d = SEL_RF;
                    end
                end
                STALL: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and select registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fwd_a_sel <= sel_a_d;
            fwd_b_sel <= sel_b_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating count of stalled cycles; only reset clears it, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl. Two instances share one stimulus stream:
// dut1 with LOAD_LAT=1 and dut3 with LOAD_LAT=3. Each is checked against its own
// hand-computed expectations. Stall counters are checked when HAZARD_PERF_CNT_EN is set.
module tb_hazard_forward_ctrl;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       id_valid;
    logic [3:0] id_rs1, id_rs2;
    logic       id_rs1_used, id_rs2_used;
    logic       ex_valid, ex_we, ex_is_load;
    logic [3:0] ex_rd;
    logic       mem_valid, mem_we;
    logic [3:0] mem_rd;

    logic [1:0] a1, b1, a3, b3;
    logic       stall1, bubble1, st1;
    logic       stall3, bubble3, st3;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc1, sc3;
    logic [31:0] snap1, snap3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_forward_ctrl #(.REG_ADDR_W(4), .LOAD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd),
        .fwd_a_sel(a1), .fwd_b_sel(b1), .stall(stall1), .bubble(bubble1),
        .state_dbg(st1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc1)
`endif
    );

    hazard_forward_ctrl #(.REG_ADDR_W(4), .LOAD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd),
        .fwd_a_sel(a3), .fwd_b_sel(b3), .stall(stall3), .bubble(bubble3),
        .state_dbg(st3)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc3)
`endif
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_used = 0; id_rs2_used = 0;
        ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rd = 0;
        mem_valid = 0; mem_we = 0; mem_rd = 0;
    endtask

    task automatic set_id(input logic [3:0] r1, input logic u1, input logic [3:0] r2, input logic u2);
        id_valid = 1; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    endtask

    task automatic set_ex(input logic v, input logic [3:0] rd, input logic ld);
        ex_valid = v; ex_we = v; ex_rd = rd; ex_is_load = ld;
    endtask

    task automatic set_mem(input logic v, input logic [3:0] rd);
        mem_valid = v; mem_we = v; mem_rd = rd;
    endtask

    task automatic randomize_inputs();
        flush = 1'($urandom_range(0, 1));
        id_valid = 1'($urandom_range(0, 1));
        id_rs1 = 4'($urandom_range(0, 15)); id_rs2 = 4'($urandom_range(0, 15));
        id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
        ex_valid = 1'($urandom_range(0, 1)); ex_we = 1'($urandom_range(0, 1));
        ex_is_load = 1'($urandom_range(0, 1)); ex_rd = 4'($urandom_range(0, 15));
        mem_valid = 1'($urandom_range(0, 1)); mem_we = 1'($urandom_range(0, 1));
        mem_rd = 4'($urandom_range(0, 15));
    endtask

    initial begin
        // Reset held 2 cycles with random inputs.
        rst = 1;
        randomize_inputs();
        tick();
        randomize_inputs();
        tick();
        rst = 0;
        idle();
        #1;
        chk("rst_a1", 32'(a1), 0);
        chk("rst_b1", 32'(b1), 0);
        chk("rst_a3", 32'(a3), 0);
        chk("rst_b3", 32'(b3), 0);
        chk("rst_stall1", 32'(stall1), 0);
        chk("rst_bubble1", 32'(bubble1), 0);
        chk("rst_stall3", 32'(stall3), 0);
        chk("rst_state3", 32'(st3), 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_sc1", sc1, 0);
        chk("rst_sc3", sc3, 0);
`endif

        // ALU chain: EX writes r3, ID reads r3 on rs1.
        set_ex(1, 4'd3, 0);
        set_id(4'd3, 1, 4'd4, 1);
        #1;
        chk("alu_stall1", 32'(stall1), 0);
        chk("alu_stall3", 32'(stall3), 0);
        tick();
        chk("alu_a1", 32'(a1), 2);
        chk("alu_b1", 32'(b1), 0);
        chk("alu_a3", 32'(a3), 2);

        // Two-back: MEM writes r5, EX writes r6.
        idle();
        set_mem(1, 4'd5);
        set_ex(1, 4'd6, 0);
        set_id(4'd5, 1, 4'd6, 1);
        tick();
        chk("twoback_a1", 32'(a1), 1);
        chk("twoback_b1", 32'(b1), 2);

        // r0 is never forwarded.
        idle();
        set_ex(1, 4'd0, 0);
        set_mem(1, 4'd0);
        set_id(4'd0, 1, 4'd0, 1);
        tick();
        chk("r0_a1", 32'(a1), 0);
        chk("r0_b1", 32'(b1), 0);

        // Unused source does not forward; used one does from MEM.
        idle();
        set_ex(1, 4'd9, 0);
        set_mem(1, 4'd10);
        set_id(4'd9, 0, 4'd10, 1);
        tick();
        chk("unused_a1", 32'(a1), 0);
        chk("unused_b1", 32'(b1), 1);

        // id_valid low registers 00 even with matching producers.
        id_valid = 0;
        id_rs1_used = 1;
        tick();
        chk("idinv_a1", 32'(a1), 0);
        chk("idinv_b1", 32'(b1), 0);

        // Priority: EX and MEM both write r2.
        idle();
        set_ex(1, 4'd2, 0);
        set_mem(1, 4'd2);
        set_id(4'd2, 1, 4'd2, 1);
        tick();
        chk("prio_a1", 32'(a1), 2);
        chk("prio_b1", 32'(b1), 2);
        chk("prio_a3", 32'(a3), 2);
        chk("prio_b3", 32'(b3), 2);

        // Load-use: load r7 in EX, ID reads r7.
        idle();
        set_ex(1, 4'd7, 1);
        set_id(4'd7, 1, 4'd1, 1);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        snap1 = sc1;
        snap3 = sc3;
`endif
        chk("lu0_stall1", 32'(stall1), 1);
        chk("lu0_bubble1", 32'(bubble1), 1);
        chk("lu0_stall3", 32'(stall3), 1);
        chk("lu0_bubble3", 32'(bubble3), 1);
        tick();
        // Selects held through the detection cycle.
        chk("lu0_hold_a1", 32'(a1), 2);
        chk("lu0_hold_b3", 32'(b3), 2);
        // Bubble in EX, load now in MEM.
        set_ex(0, 4'd0, 0);
        set_mem(1, 4'd7);
        #1;
        chk("lu1_stall1", 32'(stall1), 0);
        chk("lu1_stall3", 32'(stall3), 1);
        chk("lu1_bubble3", 32'(bubble3), 1);
        chk("lu1_state3", 32'(st3), 1);
        tick();
        chk("lu1_a1", 32'(a1), 1);
        chk("lu1_b1", 32'(b1), 0);
        chk("lu1_hold_a3", 32'(a3), 2);
        // Load in WB, no producers left.
        set_mem(0, 4'd0);
        #1;
        chk("lu2_stall3", 32'(stall3), 1);
        tick();
        #1;
        chk("lu3_stall3", 32'(stall3), 0);
        chk("lu3_bubble3", 32'(bubble3), 0);
        chk("lu3_state3", 32'(st3), 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("lu_sc1_delta", sc1 - snap1, 1);
        chk("lu_sc3_delta", sc3 - snap3, 3);
`endif
        tick();
        chk("lu3_a3", 32'(a3), 0);
        chk("lu3_b3", 32'(b3), 0);

        // Flush mid-stall for LOAD_LAT=3.
        idle();
        set_ex(1, 4'd3, 0);
        set_id(4'd3, 1, 4'd3, 1);
        tick();
        chk("pre_flush_a3", 32'(a3), 2);
        set_ex(1, 4'd7, 1);
        set_id(4'd7, 1, 4'd0, 0);
        #1;
        chk("fl0_stall3", 32'(stall3), 1);
        tick();
        set_ex(0, 4'd0, 0);
        set_mem(1, 4'd7);
        flush = 1;
        #1;
        chk("fl1_stall3", 32'(stall3), 0);
        chk("fl1_bubble3", 32'(bubble3), 0);
        chk("fl1_stall1", 32'(stall1), 0);
        tick();
        flush = 0;
        chk("fl_state3", 32'(st3), 0);
        chk("fl_a3", 32'(a3), 0);
        chk("fl_b3", 32'(b3), 0);
        chk("fl_a1", 32'(a1), 0);
        #1;
        chk("fl2_stall3", 32'(stall3), 0);

        // Flush beats a fresh load-use hazard in RUN.
        idle();
        set_ex(1, 4'd8, 1);
        set_id(4'd8, 1, 4'd0, 0);
        flush = 1;
        #1;
        chk("flhz_stall1", 32'(stall1), 0);
        chk("flhz_stall3", 32'(stall3), 0);
        tick();
        chk("flhz_state3", 32'(st3), 0);
        chk("flhz_a1", 32'(a1), 0);

        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
